alu_seq_driver: RTL

- Initiator-side sequencer for the datapath ALU (3-bit alucontrol, 32-bit a/b, combinational result/zero).
- Accepts operation requests over a valid/ready handshake and drives the ALU operand and control ports.
- Registers the ALU result and returns it over a valid/ready response handshake.
- Adds a multi-cycle unsigned multiply (low 32 bits) built from repeated ALU adds, so the datapath gains MULU without a dedicated multiplier.

---
 rtl/alu_seq_driver_if.sv | 29 ++
 rtl/alu_seq_driver.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_seq_driver_if.sv
// alu_seq_driver_if: request/response handshake plus ALU operand/result bus.
// The slave side is the sequencer; the master side is its environment (requester, consumer and ALU).
interface alu_seq_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: sequences single ALU ops and a shift-add MULU over an external ALU,
// returning registered results on a valid/ready response channel.
module alu_seq_driver #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_seq_driver_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, res_q, res_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d, err_q, err_d;
    logic        busy, mul_exit;
    logic [31:0] acc_nx, mplier_sh;

    // acc/mcand double as the latched a/b of a single op, so both busy states share one ALU mux
    assign busy         = state_q == EXEC || state_q == MUL;
    assign bus.alu_a    = busy ? acc_q : 32'd0;
    assign bus.alu_b    = busy ? mcand_q : 32'd0;
    assign bus.alu_ctrl = busy ? ctrl_q : 3'b000;
    assign bus.req_ready  = state_q == IDLE;
    assign bus.rsp_valid  = state_q == DONE;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

    always_comb begin
        acc_nx    = mplier_q[0] ? bus.alu_result : acc_q;
        mplier_sh = mplier_q >> 1;
        mul_exit  = cnt_q == 5'd31 || (EARLY_EXIT && mplier_sh == 32'd0);
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (!bus.req_op[3]) begin
                    acc_d   = bus.req_a;
                    mcand_d = bus.req_b;
                    ctrl_d  = bus.req_op[2:0];
                    state_d = EXEC;
                end else if (bus.req_op[2:0] == 3'b000) begin
                    acc_d    = 32'd0;
                    mcand_d  = bus.req_a;
                    mplier_d = bus.req_b;
                    cnt_d    = 5'd0;
                    ctrl_d   = 3'b010;
                    state_d  = MUL;
                end else begin
                    res_d   = 32'd0;
                    zero_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            EXEC: begin
                res_d   = bus.alu_result;
                zero_d  = bus.alu_zero;
                err_d   = 1'b0;
                state_d = DONE;
            end
            MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + 5'd1;
                if (mul_exit) begin
                    res_d   = acc_nx;
                    zero_d  = acc_nx == 32'd0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            ctrl_q   <= 3'b000;
            cnt_q    <= 5'd0;
            res_q    <= 32'd0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end
endmodule
